// File: rtl/attack_map_if.sv
// attack_map_if: request and result bundle for attack_map_builder.
// master drives the position, slave returns the attack map.
interface attack_map_if;
  logic        start;
  logic        enemy_is_white;
  logic [63:0] e_pawns;
  logic [63:0] e_knights;
  logic [63:0] e_orth;
  logic [63:0] e_diag;
  logic [63:0] e_king;
  logic [63:0] own_king;
  logic [63:0] own_pieces;
  logic [63:0] occupancy;
  logic        busy;
  logic        done;
  logic [63:0] attacked;
  logic        in_check;
  logic [63:0] king_moves;

  modport master (
    output start,
    output enemy_is_white,
    output e_pawns,
    output e_knights,
    output e_orth,
    output e_diag,
    output e_king,
    output own_king,
    output own_pieces,
    output occupancy,
    input  busy,
    input  done,
    input  attacked,
    input  in_check,
    input  king_moves
  );

  modport slave (
    input  start,
    input  enemy_is_white,
    input  e_pawns,
    input  e_knights,
    input  e_orth,
    input  e_diag,
    input  e_king,
    input  own_king,
    input  own_pieces,
    input  occupancy,
    output busy,
    output done,
    output attacked,
    output in_check,
    output king_moves
  );
endinterface

// File: rtl/attack_map_builder.sv
// attack_map_builder: multi-cycle enemy attack map, check and king moves.
// Optional ATTACK_MAP_EARLY_EXIT_EN ends slider phases once rays die out.
module attack_map_builder #(
  parameter int SLIDE_STEPS = 7
) (
  input logic         clk,
  input logic         rst_n,
  attack_map_if.slave bus
);

  localparam logic [63:0] NOT_A  = 64'hfefe_fefe_fefe_fefe;
  localparam logic [63:0] NOT_H  = 64'h7f7f_7f7f_7f7f_7f7f;
  localparam logic [63:0] NOT_AB = 64'hfcfc_fcfc_fcfc_fcfc;
  localparam logic [63:0] NOT_GH = 64'h3f3f_3f3f_3f3f_3f3f;
  localparam logic [2:0]  LAST   = 3'(SLIDE_STEPS - 1);

  typedef enum logic [2:0] {
    IDLE,
    LEAP,
    ORTHO,
    DIAG,
    FINISH
  } state_t;

  function automatic logic [63:0] king_att(
    input logic [63:0] k
  );
    logic [63:0] r;
    r = (k << 8) | (k >> 8);
    r = r | (((k << 1) | (k << 9) | (k >> 7)) & NOT_A);
    r = r | (((k >> 1) | (k >> 9) | (k << 7)) & NOT_H);
    return r;
  endfunction

  function automatic logic [63:0] knight_att(
    input logic [63:0] n
  );
    logic [63:0] r;
    r = ((n << 17) & NOT_A) | ((n << 15) & NOT_H);
    r = r | ((n << 10) & NOT_AB) | ((n << 6) & NOT_GH);
    r = r | ((n >> 17) & NOT_H) | ((n >> 15) & NOT_A);
    r = r | ((n >> 10) & NOT_GH) | ((n >> 6) & NOT_AB);
    return r;
  endfunction

  function automatic logic [63:0] pawn_att(
    input logic [63:0] p,
    input logic        white
  );
    logic [63:0] r;
    if (white)
      r = ((p << 7) & NOT_H) | ((p << 9) & NOT_A);
    else
      r = ((p >> 9) & NOT_H) | ((p >> 7) & NOT_A);
    return r;
  endfunction

  // d: ortho N,S,E,W / diag NE,NW,SE,SW
  function automatic logic [63:0] step_ray(
    input logic [63:0] f,
    input logic        dg,
    input logic [1:0]  d
  );
    logic [63:0] r;
    r = '0;
    unique case ({dg, d})
      3'b000: r = f << 8;
      3'b001: r = f >> 8;
      3'b010: r = (f << 1) & NOT_A;
      3'b011: r = (f >> 1) & NOT_H;
      3'b100: r = (f << 9) & NOT_A;
      3'b101: r = (f << 7) & NOT_H;
      3'b110: r = (f >> 7) & NOT_A;
      3'b111: r = (f >> 9) & NOT_H;
      default: r = '0;
    endcase
    return r;
  endfunction

  state_t state;
  state_t nxt;

  logic             white_r;
  logic [63:0]      pawns_r;
  logic [63:0]      knights_r;
  logic [63:0]      eking_r;
  logic [63:0]      own_king_r;
  logic [63:0]      own_r;
  logic [63:0]      block_r;
  logic [3:0][63:0] ofr;
  logic [3:0][63:0] dfr;
  logic [63:0]      acc;
  logic [2:0]       step;

  logic             done_q;
  logic [63:0]      att_q;
  logic             chk_q;
  logic [63:0]      km_q;

  logic             load;
  logic             leap_en;
  logic             slide_en;
  logic             fin_en;

  logic             is_diag;
  logic [3:0][63:0] cur;
  logic [3:0][63:0] hit;
  logic [3:0][63:0] adv;
  logic [63:0]      hits_any;
  logic             all_clear;
  logic             last_step;

  // Our king is not a blocker, so rays x-ray through it.
  always_comb begin
    is_diag  = (state == DIAG);
    cur      = is_diag ? dfr : ofr;
    hit      = '0;
    adv      = '0;
    hits_any = '0;
    for (int i = 0; i < 4; i++) begin
      hit[i]   = step_ray(cur[i], is_diag, 2'(i));
      adv[i]   = hit[i] & ~block_r;
      hits_any = hits_any | hit[i];
    end
    all_clear = ~|{adv[0], adv[1], adv[2], adv[3]};
  end

`ifdef ATTACK_MAP_EARLY_EXIT_EN
  assign last_step = (step == LAST) || all_clear;
`else
  assign last_step = (step == LAST);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (bus.start) nxt = LEAP;
      LEAP:    nxt = ORTHO;
      ORTHO:   if (last_step) nxt = DIAG;
      DIAG:    if (last_step) nxt = FINISH;
      FINISH:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    load     = 1'b0;
    leap_en  = 1'b0;
    slide_en = 1'b0;
    fin_en   = 1'b0;
    unique case (1'b1)
      state == IDLE:   load     = bus.start;
      state == LEAP:   leap_en  = 1'b1;
      state == ORTHO:  slide_en = 1'b1;
      state == DIAG:   slide_en = 1'b1;
      state == FINISH: fin_en   = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      white_r    <= 1'b0;
      pawns_r    <= '0;
      knights_r  <= '0;
      eking_r    <= '0;
      own_king_r <= '0;
      own_r      <= '0;
      block_r    <= '0;
      ofr        <= '0;
      dfr        <= '0;
      acc        <= '0;
      step       <= '0;
      done_q     <= 1'b0;
      att_q      <= '0;
      chk_q      <= 1'b0;
      km_q       <= '0;
    end else begin
      done_q <= fin_en;
      if (load) begin
        white_r    <= bus.enemy_is_white;
        pawns_r    <= bus.e_pawns;
        knights_r  <= bus.e_knights;
        eking_r    <= bus.e_king;
        own_king_r <= bus.own_king;
        own_r      <= bus.own_pieces;
        block_r    <= bus.occupancy & ~bus.own_king;
        ofr        <= {4{bus.e_orth}};
        dfr        <= {4{bus.e_diag}};
        acc        <= '0;
        step       <= '0;
      end
      if (leap_en) begin
        acc  <= pawn_att(pawns_r, white_r)
              | knight_att(knights_r)
              | king_att(eking_r);
        step <= '0;
      end
      if (slide_en) begin
        acc  <= acc | hits_any;
        step <= last_step ? 3'd0 : step + 3'd1;
        if (is_diag)
          dfr <= adv;
        else
          ofr <= adv;
      end
      if (fin_en) begin
        att_q <= acc;
        chk_q <= |(acc & own_king_r);
        km_q  <= king_att(own_king_r) & ~own_r & ~acc;
      end
    end
  end

  assign bus.busy       = (state != IDLE);
  assign bus.done       = done_q;
  assign bus.attacked   = att_q;
  assign bus.in_check   = chk_q;
  assign bus.king_moves = km_q;

endmodule

// File: tb/tb_attack_map_builder.sv
// tb_attack_map_builder: directed checks of attack_map_builder
// with hand-computed attack maps, latencies and handshake timing.
module tb_attack_map_builder;

`ifdef ATTACK_MAP_EARLY_EXIT_EN
  localparam int LONE_LAT = 4;
  localparam int ROOK_LAT = 10;
`else
  localparam int LONE_LAT = 16;
  localparam int ROOK_LAT = 16;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  attack_map_if ifc ();

  attack_map_builder #(
    .SLIDE_STEPS(7)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifc)
  );

  int vectors     = 0;
  int miscompares = 0;
  int lat;
  int ndone;
  int t_first;
  int t_second;

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic setup(
    input logic        w,
    input logic [63:0] p,
    input logic [63:0] n,
    input logic [63:0] o,
    input logic [63:0] d,
    input logic [63:0] k,
    input logic [63:0] ok,
    input logic [63:0] op,
    input logic [63:0] occ
  );
    ifc.enemy_is_white = w;
    ifc.e_pawns        = p;
    ifc.e_knights      = n;
    ifc.e_orth         = o;
    ifc.e_diag         = d;
    ifc.e_king         = k;
    ifc.own_king       = ok;
    ifc.own_pieces     = op;
    ifc.occupancy      = occ;
  endtask

  task automatic scramble();
    ifc.enemy_is_white = 1'($urandom);
    ifc.e_pawns        = {$urandom, $urandom};
    ifc.e_knights      = {$urandom, $urandom};
    ifc.e_orth         = {$urandom, $urandom};
    ifc.e_diag         = {$urandom, $urandom};
    ifc.e_king         = {$urandom, $urandom};
    ifc.own_king       = {$urandom, $urandom};
    ifc.own_pieces     = {$urandom, $urandom};
    ifc.occupancy      = {$urandom, $urandom};
  endtask

  task automatic run(output int cyc);
    @(negedge clk);
    ifc.start = 1'b1;
    @(posedge clk);
    #1;
    ifc.start = 1'b0;
    scramble();
    cyc = 0;
    while (cyc < 40 && ifc.done !== 1'b1) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("no_timeout", 64'(cyc < 40), 64'd1);
  endtask

  task automatic chk_res(
    input string       tag,
    input logic [63:0] att,
    input logic        ic,
    input logic [63:0] km
  );
    chk({tag, "_attacked"}, ifc.attacked, att);
    chk({tag, "_in_check"}, 64'(ifc.in_check), 64'(ic));
    chk({tag, "_king_moves"}, ifc.king_moves, km);
  endtask

  initial begin
    ifc.start = 1'b0;
    setup(1'b0, '0, '0, '0, '0, '0, '0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(ifc.busy), 64'd0);
    chk("rst_done", 64'(ifc.done), 64'd0);
    chk_res("rst", 64'd0, 1'b0, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // lone kings
    setup(1'b0, '0, '0, '0, '0, 64'h1 << 60, 64'h10, 64'h10,
          (64'h1 << 60) | 64'h10);
    run(lat);
    chk("lone_latency", 64'(lat), 64'(LONE_LAT));
    chk_res("lone", 64'h2838_0000_0000_0000, 1'b0, 64'h3828);
    @(posedge clk);
    #1;
    chk("done_pulse_len", 64'(ifc.done), 64'd0);
    chk("idle_busy", 64'(ifc.busy), 64'd0);

    // reset mid-run
    setup(1'b0, '0, '0, 64'h1, '0, 64'h1 << 63, 64'h10, 64'h10,
          (64'h1 << 63) | 64'h11);
    @(negedge clk);
    ifc.start = 1'b1;
    @(posedge clk);
    #1;
    ifc.start = 1'b0;
    chk("run_busy", 64'(ifc.busy), 64'd1);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(ifc.busy), 64'd0);
    chk_res("abort", 64'd0, 1'b0, 64'd0);
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (ifc.done === 1'b1) ndone++;
      if (i == 3) rst_n = 1'b1;
    end
    chk("abort_no_done", 64'(ndone), 64'd0);

    // rook x-ray through our king
    setup(1'b0, '0, '0, 64'h1, '0, 64'h1 << 63, 64'h10, 64'h10,
          (64'h1 << 63) | 64'h11);
    run(lat);
    chk("rook_latency", 64'(lat), 64'(ROOK_LAT));
    chk_res("rook", 64'h41C1_0101_0101_01FE, 1'b1, 64'h3800);

    // bishop blocked by own pawn on d2
    setup(1'b0, '0, '0, '0, 64'h1 << 25, 64'h1 << 63, 64'h10, 64'h810,
          (64'h1 << 63) | (64'h1 << 25) | 64'h810);
    run(lat);
    chk_res("diag_blk", 64'h60D0_0805_0005_0800, 1'b0, 64'h3028);
    setup(1'b0, '0, '0, '0, 64'h1 << 25, 64'h1 << 63, 64'h10, 64'h10,
          (64'h1 << 63) | (64'h1 << 25) | 64'h10);
    run(lat);
    chk("diag_open_check", 64'(ifc.in_check), 64'd1);
    chk("diag_open_e1", 64'(ifc.attacked[4]), 64'd1);

    // pawn direction and file wrap
    setup(1'b1, 64'h1 << 28, '0, '0, '0, '0, '0, '0, 64'h1 << 28);
    run(lat);
    chk_res("pawn_w", 64'h0000_0028_0000_0000, 1'b0, 64'd0);
    setup(1'b0, 64'h1 << 28, '0, '0, '0, '0, '0, '0, 64'h1 << 28);
    run(lat);
    chk("pawn_b", ifc.attacked, 64'h0000_0000_0028_0000);
    setup(1'b1, 64'h1 << 31, '0, '0, '0, '0, '0, '0, 64'h1 << 31);
    run(lat);
    chk("pawn_h4", ifc.attacked, 64'h0000_0040_0000_0000);

    // knight on a1, then an empty enemy set
    setup(1'b0, '0, 64'h1, '0, '0, '0, 64'h10, 64'h10, 64'h11);
    run(lat);
    chk_res("knight", 64'h0000_0000_0002_0400, 1'b0, 64'h3828);
    setup(1'b0, '0, '0, '0, '0, '0, 64'h10, 64'h10, 64'h10);
    run(lat);
    chk_res("empty", 64'd0, 1'b0, 64'h3828);

    // start held high: one done per LONE_LAT+1 cycles
    setup(1'b0, '0, '0, '0, '0, 64'h1 << 60, 64'h10, 64'h10,
          (64'h1 << 60) | 64'h10);
    @(negedge clk);
    ifc.start = 1'b1;
    ndone    = 0;
    t_first  = -1;
    t_second = -1;
    for (int t = 1; t <= 40; t++) begin
      @(posedge clk);
      #1;
      if (ifc.done === 1'b1) begin
        ndone++;
        if (t_first < 0) t_first = t;
        else if (t_second < 0) t_second = t;
      end
    end
    ifc.start = 1'b0;
    chk("hold_first_done", 64'(t_first), 64'(LONE_LAT + 1));
    chk("hold_period", 64'(t_second - t_first), 64'(LONE_LAT + 1));
    chk("hold_count", 64'(ndone), 64'(40 / (LONE_LAT + 1)));
    chk_res("hold", 64'h2838_0000_0000_0000, 1'b0, 64'h3828);
    repeat (20) @(posedge clk);
    #1;
    chk("drain_busy", 64'(ifc.busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/attack_map_builder.md
Name: attack_map_builder

Overview:
- Sequential consumer of the king attack generator and its sibling attack generators.
- Given the enemy piece bitboards, accumulates the full enemy attacked-square map over several cycles.
- Reports check on our king and our legal king destinations.
- Feeds the move-legality filter.
- Bit order: bit 0 = a1, bit 7 = h1, bit 63 = h8; north = <<8, east = <<1.

Parameters:
- SLIDE_STEPS, 7, ray-extension cycles per slider phase; the legal range is 1..7.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; accepted only in IDLE.
- enemy_is_white  in  1  enemy pawn direction; 1 means enemy pawns attack northward.
- e_pawns  in  64  enemy pawns.
- e_knights  in  64  enemy knights.
- e_orth  in  64  enemy rooks|queens.
- e_diag  in  64  enemy bishops|queens.
- e_king  in  64  enemy king, one-hot.
- own_king  in  64  our king, one-hot.
- own_pieces  in  64  all our pieces, including the king.
- occupancy  in  64  all pieces, both sides.
- busy  out  1  high from the accepting edge until done.
- done  out  1  one-cycle pulse when results are valid.
- attacked  out  64  enemy attacked squares.
- in_check  out  1  |(attacked & own_king).
- king_moves  out  64  king_attack(own_king) & ~own_pieces & ~attacked.

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE.
  - busy, done, in_check = 0; attacked, king_moves = 0.
  - All internal frontiers = 0.
  - Reset mid-operation aborts the run; done does not pulse.
- Start:
  - In IDLE, start=1 registers all input bitboards on that edge (T0) and sets busy.
  - Inputs changing afterwards have no effect on the run.
  - start while busy is ignored.
- FSM states:
  - IDLE -> LEAP -> ORTHO -> DIAG -> FINISH -> IDLE.
- LEAP (1 cycle): acc = pawn | knight | king attacks of e_king.
  - Pawns, white: (p<<7)&7f7f.. | (p<<9)&fefe..
  - Pawns, black: (p>>9)&7f7f.. | (p>>7)&fefe..
  - Knights: standard 8-offset with 0x3f3f../0xfcfc../7f../fe.. file masks.
  - King: identical to the king attack generator.
- ORTHO: four directional frontiers N/S/E/W, each initialised to e_orth.
  - Each cycle: f = shift(f) & filemask; acc |= f; f &= ~block.
  - block = occupancy & ~own_king. Our king is x-rayed, so squares behind it are attacked.
  - A blocker square is itself marked attacked.
  - The phase lasts exactly SLIDE_STEPS cycles.
- DIAG: same as ORTHO with NE/NW/SE/SW frontiers initialised to e_diag.
- FINISH (1 cycle):
  - Register attacked = acc.
  - Register in_check.
  - Register king_moves using the identical king-shift/mask formula on own_king.
  - Pulse done.
  - Clear busy.
  - Return to IDLE.
- Latency, default: done high in the cycle after edge T0+16 (1 + 7 + 7 + 1).
- Outputs hold their values until the next FINISH.
- A new start is accepted on the edge where done is high; busy then stays 1.
- Boundaries:
  - No file wrap: h->a and a->h shifts are masked.
  - Rank overflow falls off the shift.
  - Empty enemy set gives attacked=0 and king_moves = all king neighbours not own.
  - own_king=0 gives in_check=0 and king_moves=0.

Optional Feature:
- Macro: ATTACK_MAP_EARLY_EXIT_EN.
- Defined:
  - Each slider phase ends after the first step leaving all four of its frontiers zero, capped at SLIDE_STEPS.
  - Each slider phase lasts 1..SLIDE_STEPS cycles.
  - Total latency is 4..16 cycles.
- Undefined: fixed latency of 2*SLIDE_STEPS+2.
- The attacked, in_check and king_moves results are identical either way.

Test Plan:
- Reset mid-run:
  - Assert rst_n=0 at cycle 5 of a run -> busy=0, done never pulses, all outputs 0.
  - After reset release, a new start completes normally.
- Lone kings:
  - e_king=bit60 (e8), own_king=bit4 (e1), own_pieces=0x10, occupancy = both kings.
  - done at T0+16; attacked=0x2838000000000000; in_check=0; king_moves=0x3828.
- Rook x-ray:
  - Add e_orth=bit0 (a1), with e_king moved to bit63.
  - in_check=1.
  - attacked includes 0xFE and 0x0101010101010100; bit5 (f1) is set.
  - king_moves=0x3800.
- Blocked diagonal:
  - e_diag=bit25 (b4), own pawn bit11 (d2) in own_pieces and occupancy -> attacked[11]=1, attacked[4]=0, in_check=0.
  - Remove the pawn -> in_check=1.
- Pawn direction and wrap:
  - e_pawns=bit28 (e4), enemy_is_white=1 -> bits 35,37 set; with enemy_is_white=0 -> bits 19,21 set.
  - e_pawns=bit31 (h4), white -> bit38 only; bit40 clear.
- Handshake and early exit:
  - start held high across the whole run -> exactly one done per 17 cycles; mid-run starts ignored.
  - With ATTACK_MAP_EARLY_EXIT_EN and only the kings present -> done at T0+4.
